// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// mapping of log-shifter levels onto pipeline register banks.
package pipe_barrel_shifter_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_SLL = 3'b001,
    OP_ROR = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } shift_op_e;

  // Level lvl (shift by 2^lvl) of an l-level shifter lives in this bank;
  // the largest shift is applied first, in bank 0.
  function automatic int level_stage(input int lvl, input int l, input int p);
    return ((l - 1 - lvl) * p) / l;
  endfunction

endpackage

// File: rtl/pipe_barrel_shifter_shift_level.sv
// One combinational log-shifter level: shifts or rotates by the fixed amount
// AMT when enabled, otherwise passes the operand through.
module pipe_barrel_shifter_shift_level
  import pipe_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_ROL:  data_o = (data_i << AMT) | (data_i >> (WIDTH - AMT));
        OP_SLL:  data_o = data_i << AMT;
        OP_ROR:  data_o = (data_i >> AMT) | (data_i << (WIDTH - AMT));
        OP_SRL:  data_o = data_i >> AMT;
        // Sign comes from the original operand, not from this level's input.
        OP_SRA:  data_o = (data_i >> AMT) | ({WIDTH{sign_i}} << (WIDTH - AMT));
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides; the
// log-shifter levels are spread across PIPE_STAGES register banks.
module pipe_barrel_shifter
  import pipe_barrel_shifter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_cnt,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero
);

  localparam int L = $clog2(WIDTH);

  typedef struct packed {
    logic [L-1:0] cnt;
    logic [2:0]   op;
    logic         sign;
  } meta_t;

  meta_t                  meta_in [PIPE_STAGES];
  logic [WIDTH-1:0]       din     [PIPE_STAGES];
  logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] free;
  logic                   zero_q;

  // A bank can take new contents when it, or any bank downstream of it, is
  // empty, or when the consumer is draining the last bank.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_free
    assign free[k] = out_ready | ~(&vld_q[PIPE_STAGES-1:k]);
  end

  assign in_ready  = free[0];
  assign out_valid = vld_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_zero  = zero_q;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign din[0]     = in_data;
      assign meta_in[0] = '{cnt: in_cnt, op: in_op, sign: in_data[WIDTH-1]};
    end else begin : g_src
      meta_t meta_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_q <= '0;
        end else if (free[k-1]) begin
          meta_q <= meta_in[k-1];
        end
      end
      assign din[k]     = data_q[k-1];
      assign meta_in[k] = meta_q;
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
      localparam int LI = L - 1 - j;
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] q;

      if (j == 0) begin : g_first
        assign src = din[k];
      end else begin : g_next
        assign src = g_lvl[j-1].q;
      end

      if (level_stage(LI, L, PIPE_STAGES) == k) begin : g_on
        pipe_barrel_shifter_shift_level #(
          .WIDTH (WIDTH),
          .AMT   (1 << LI)
        ) u_level (
          .data_i (src),
          .en_i   (meta_in[k].cnt[LI]),
          .op_i   (meta_in[k].op),
          .sign_i (meta_in[k].sign),
          .data_o (q)
        );
      end else begin : g_off
        assign q = src;
      end
    end

    // ---- bank k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
      end else if (free[k]) begin
        data_q[k] <= g_lvl[L-1].q;
        if (k == 0) begin
          vld_q[k] <= in_valid;
        end else begin
          vld_q[k] <= vld_q[(k == 0) ? 0 : k-1];
        end
      end
    end

    if (k == PIPE_STAGES - 1) begin : g_zero
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          zero_q <= 1'b0;
        end else if (free[k]) begin
          zero_q <= (g_lvl[L-1].q == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter (WIDTH=16, PIPE_STAGES=2).
module tb_pipe_barrel_shifter;

  localparam int W = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [3:0]   in_cnt = '0;
  logic [2:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_zero;

  pipe_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         lat;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] cur_exp = '0;
  logic         cur_lat = 1'b0;
  int           cyc = 0;
  int           n_out = 0;
  int           checks = 0;
  int           errors = 0;
  logic         rand_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [3:0] c,
                                         input logic [2:0] op);
    logic [W-1:0] r;
    int n;
    n = int'(c);
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0:    r[i] = d[(i - n + W) % W];
        3'd1:    r[i] = (i >= n) ? d[i - n] : 1'b0;
        3'd2:    r[i] = d[(i + n) % W];
        3'd3:    r[i] = (i + n < W) ? d[i + n] : 1'b0;
        3'd4:    r[i] = (i + n < W) ? d[i + n] : d[W-1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_zero", 32'(out_zero), 32'(e.data == '0));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(P));
        end
        n_out++;
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cur_lat, cyc});
    end
  end

  // Offer one item and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [W-1:0] d, input logic [3:0] c, input logic [2:0] op,
                      input logic [W-1:0] exp, input logic lat);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = op;
    cur_exp  = exp;
    cur_lat  = lat;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    int           n0;
    logic [W-1:0] d;
    logic [3:0]   c;
    logic [2:0]   op;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Rotates with latency
    out_ready = 1'b1;
    send(16'h8001, 4'd1, 3'b000, 16'h0003, 1'b1);
    send(16'h8001, 4'd1, 3'b010, 16'hC000, 1'b1);
    idle(1);
    drain("drain_rot");

    // Full-count boundaries
    send(16'h8000, 4'd15, 3'b100, 16'hFFFF, 1'b0);
    send(16'h8000, 4'd15, 3'b011, 16'h0001, 1'b0);
    send(16'h8000, 4'd15, 3'b001, 16'h0000, 1'b0);
    idle(1);
    drain("drain_cnt15");

    // Zero count for every op, and pass-through op
    for (int o = 0; o < 8; o++) send(16'hA5C3, 4'd0, 3'(o), 16'hA5C3, 1'b0);
    send(16'h1234, 4'd5, 3'b111, 16'h1234, 1'b0);
    idle(1);
    drain("drain_cnt0");

    // Backpressure: two accepted, third stalls, output held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; in_cnt = 4'd4; in_op = 3'b001; cur_exp = 16'h0010; cur_lat = 1'b0;
    @(posedge clk); #1;
    in_data = 16'hF000; in_cnt = 4'd8; in_op = 3'b011; cur_exp = 16'h00F0;
    @(posedge clk); #1;
    in_data = 16'h1234; in_cnt = 4'd4; in_op = 3'b010; cur_exp = 16'h4123;
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held = out_data;
    repeat (3) @(negedge clk);
    check("bp_hold_data", 32'(out_data), 32'(held));
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n0 = n_out;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("bp_no_gap", 32'(n_out - n0), 32'd3);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with two items in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h00FF, 4'd1, 3'b001, 16'h01FE, 1'b0);
    send(16'h00FF, 4'd2, 3'b001, 16'h03FC, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    sb.delete();
    n0 = n_out;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_stale", 32'(n_out - n0), 32'd0);
    @(posedge clk); #1;

    // Random ops against the model with random out_ready
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 7) == 0) idle(1);
          d  = W'($urandom);
          c  = 4'($urandom);
          op = 3'($urandom_range(0, 7));
          send(d, c, op, model(d, c, op), 1'b0);
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
